cpu_write_buffer: RTL and testbench
===================================

// Module: cpu_write_buffer
// PURPOSE
//  Posted-write buffer between CPU bus interface and SDRAM controller, beside the two-way read cache.
//  Each CPU write goes to the cache first (update/invalidate) and waits for its cpu_wr_ack.
//  It is then queued in a DEPTH-entry FIFO and acknowledged to the CPU. Queued writes drain to SDRAM in the background.
//  Flags reads that alias a pending write so upstream can stall them (RAW hazard).
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, 2..16
//  AW     32  address width
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  cpu_req        in   1   CPU write request; held until cpu_ack seen
//  cpu_addr       in   AW  byte address (bit 0 ignored)
//  cpu_data       in   16  write data
//  cpu_uds_n      in   1   0 = upper byte written
//  cpu_lds_n      in   1   0 = lower byte written
//  cpu_ack        out  1   write accepted (posted)
//  rd_addr        in   AW  address of pending CPU read, for hazard check
//  rd_hold        out  1   rd_addr[AW-1:1] matches a queued/in-flight entry
//  cache_req      out  1   write notify to cache (cpu_rw=0 at cache)
//  cache_wr_ack   in   1   cache has actioned the write
//  sdram_req      out  1   drain request
//  sdram_addr     out  AW  drain address, bit 0 = 0
//  sdram_data     out  16  drain data
//  sdram_uds_n    out  1   drain byte enable, upper
//  sdram_lds_n    out  1   drain byte enable, lower
//  sdram_wr_ack   in   1   one-cycle pulse: word written to SDRAM
//  empty          out  1   no queued or in-flight entry
// BEHAVIOUR
//  Reset values: all outputs 0 except empty=1 and sdram_uds_n=sdram_lds_n=1. FIFO pointers and count are cleared.
//  Front FSM:
//   F_IDLE: leave when cpu_req=1 and count<DEPTH.
//    Latch addr/data/enables, assert cache_req, go to F_CACHE.
//    If full, stay in F_IDLE; cache_req is not asserted.
//   F_CACHE: hold cache_req until cache_wr_ack=1.
//    Then drop cache_req, push the entry, assert cpu_ack, go to F_ACK.
//   F_ACK: hold cpu_ack until cpu_req=0, then go to F_IDLE.
//   Latency, cache idle: cpu_req to cpu_ack = cache latency + 2 clk.
//  Drain FSM:
//   D_IDLE: if count>0, present the head entry, assert sdram_req, go to D_BUSY.
//   D_BUSY: hold sdram_req and outputs stable until sdram_wr_ack.
//    Then pop, drop sdram_req for >=1 clk, go to D_IDLE.
//  Push and pop in the same cycle: count is unchanged. Pointers wrap modulo DEPTH.
//  count width is clog2(DEPTH)+1, so count==DEPTH is full.
//  The head entry stays counted, and stays in the rd_hold compare, until popped.
//  rd_hold is combinational over all valid entries; it also includes the latched F_CACHE entry.
//  empty = (count==0) and front FSM not in F_CACHE.
//  An sdram_wr_ack while in D_IDLE is ignored.
//  Reset mid-operation: queued writes are discarded and sdram_req drops asynchronously.
//   The host asserts reset only when empty=1, or accepts the loss.
// CONFIGURATION
//  WRBUF_MERGE_EN defined: a write merges into the tail entry when all hold:
//   same addr[AW-1:1] as tail; tail is valid; tail is not the in-flight head.
//   Only enabled bytes are overwritten; enables are ANDed (active-low); count is unchanged.
//   The cache notify still occurs.
//  WRBUF_MERGE_EN undefined: every write allocates a new entry.
// STRUCTURE
//  Shared package minimig_cache_pkg:
//   WRBUF_ENTRY_W = AW-1+16+2
//   field offsets for addr/data/uds_n/lds_n within an entry
//   front/drain state encodings
//  Sub-module wrbuf_fifo: storage array, head/tail pointers, count, per-entry address compare output.
//  Both FSMs stay in cpu_write_buffer.
// TESTING
//  1. Single write 0x00001234 data 0xBEEF, both bytes.
//     Expect: cache_req, then cpu_ack; sdram_req with addr 0x00001234; empty=1 after sdram_wr_ack.
//  2. Five back-to-back writes, DEPTH=4, sdram_wr_ack withheld.
//     Expect: 4 cpu_acks; 5th stalls in F_IDLE with cache_req=0; after one sdram_wr_ack the 5th completes.
//  3. Push and pop on the same clk.
//     Expect: count stays 2; drain order matches CPU order.
//  4. Queue write to 0x100; rd_addr=0x101.
//     Expect: rd_hold=1. rd_addr=0x102 gives rd_hold=0. rd_hold=0 after the drain ack.
//  5. MERGE_EN: upper-byte write 0xAA00 then lower-byte write 0x0055 to 0x200, drain stalled.
//     Expect: one entry, data 0xAA55, both enables 0.
//     Without MERGE_EN: two entries.
//  6. Assert reset while in D_BUSY with 3 entries.
//     Expect: sdram_req=0 immediately, empty=1, cpu_ack=0.

Source files
------------

// File: rtl/minimig_cache_pkg.sv
// Shared definitions for the posted-write buffer beside the read cache.
//
// An entry is packed LSB-first as:
//   [0]                       lds_n  (active-low lower byte enable)
//   [1]                       uds_n  (active-low upper byte enable)
//   [17:2]                    data
//   [AW-1+17:18]              word address (byte address bit 0 dropped)
// WRBUF_ENTRY_W is the width for the default 32-bit address; other widths
// use wrbuf_entry_w(aw).
package minimig_cache_pkg;

  localparam int WRBUF_DEFAULT_AW = 32;
  localparam int WRBUF_DATA_W     = 16;

  localparam int WRBUF_LDS_OFF  = 0;
  localparam int WRBUF_UDS_OFF  = 1;
  localparam int WRBUF_DATA_OFF = 2;
  localparam int WRBUF_ADDR_OFF = WRBUF_DATA_OFF + WRBUF_DATA_W;

  function automatic int wrbuf_entry_w(input int aw);
    return aw - 1 + WRBUF_DATA_W + 2;
  endfunction

  localparam int WRBUF_ENTRY_W = wrbuf_entry_w(WRBUF_DEFAULT_AW);

  // Front FSM: accepts one CPU write, notifies the cache, posts it.
  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_CACHE = 2'd1,
    F_ACK   = 2'd2
  } wrbuf_front_t;

  // Drain FSM: moves the FIFO head into SDRAM.
  typedef enum logic {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } wrbuf_drain_t;

  // Debug view of both FSMs and the FIFO occupancy (count zero-extended).
  typedef struct packed {
    wrbuf_front_t front;
    wrbuf_drain_t drain;
    logic [4:0]   count;
  } wrbuf_dbg_t;

endpackage

// File: rtl/wrbuf_fifo.sv
// Storage FIFO for the posted-write buffer.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset (clears pointers/count)
//   push/push_entry  append an entry at the tail
//   merge/merge_entry overwrite the most recently pushed (tail) entry in place
//   pop              retire the head entry
//   cmp_addr         word address compared against every valid entry
//   head_entry       oldest entry
//   tail_entry       newest entry
//   count            number of valid entries (DEPTH means full)
//   match            per-entry hit: entry valid and its address equals cmp_addr
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wrbuf_fifo
  import minimig_cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int W     = WRBUF_ENTRY_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_entry,
  input  logic             merge,
  input  logic [W-1:0]     merge_entry,
  input  logic             pop,
  input  logic [AW-2:0]    cmp_addr,
  output logic [W-1:0]     head_entry,
  output logic [W-1:0]     tail_entry,
  output logic [CW-1:0]    count,
  output logic [DEPTH-1:0] match
);

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [PW-1:0]    last_ptr;
  logic [DEPTH-1:0] valid;

  assign last_ptr   = tail_ptr - PW'(1);
  assign head_entry = mem[head_ptr];
  assign tail_entry = mem[last_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only looked at while it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_ptr] <= push_entry;
    end else if (merge) begin
      mem[last_ptr] <= merge_entry;
    end
  end

  // Entry i is valid when its distance from the head is below count.
  always_comb begin
    valid = '0;
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - head_ptr} < count);
      match[i] = valid[i] && (mem[i][WRBUF_ADDR_OFF +: AW-1] == cmp_addr);
    end
  end

endmodule

// File: rtl/cpu_write_buffer.sv
// Posted-write buffer between the CPU bus interface and the SDRAM controller.
// Each CPU write is first shown to the read cache, then queued and
// acknowledged; queued writes drain to SDRAM in the background. Reads that
// alias a pending write are flagged on rd_hold so upstream can stall them.
//
// Optional feature: define WRBUF_MERGE_EN to merge a write into the tail
// entry (same word address, tail not the in-flight head) instead of
// allocating a new entry.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   cpu_req/cpu_ack              CPU write handshake
//   cpu_addr/cpu_data            byte address (bit 0 ignored) and data
//   cpu_uds_n/cpu_lds_n          active-low byte enables
//   rd_addr/rd_hold              read-after-write hazard check
//   cache_req/cache_wr_ack       write notify to the cache
//   sdram_req/sdram_wr_ack       drain handshake
//   sdram_addr/sdram_data        drain word (address bit 0 forced to 0)
//   sdram_uds_n/sdram_lds_n      drain byte enables
//   empty                        nothing queued, in flight or at the cache
//   dbg                          front/drain FSM state and FIFO count
//
// Handshakes (all level request / acknowledge):
//   cpu_req is held by the CPU until it sees cpu_ack; cpu_ack stays high
//   until cpu_req falls. cache_req is held until a cycle with cache_wr_ack.
//   sdram_req and the sdram_* fields are held stable until a one-cycle
//   sdram_wr_ack, after which sdram_req is low for at least one cycle.
module cpu_write_buffer
  import minimig_cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_data,
  input  logic          cpu_uds_n,
  input  logic          cpu_lds_n,
  output logic          cpu_ack,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_hold,
  output logic          cache_req,
  input  logic          cache_wr_ack,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_data,
  output logic          sdram_uds_n,
  output logic          sdram_lds_n,
  input  logic          sdram_wr_ack,
  output logic          empty,
  output wrbuf_dbg_t    dbg
);

  localparam int W  = wrbuf_entry_w(AW);
  localparam int CW = $clog2(DEPTH) + 1;

  wrbuf_front_t     front_q, front_d;
  wrbuf_drain_t     drain_q, drain_d;
  logic [W-1:0]     lat_entry;
  logic [W-1:0]     head_entry;
  logic [W-1:0]     tail_entry;
  logic [W-1:0]     merge_entry;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] match;
  logic             front_take;
  logic             push;
  logic             merge;
  logic             can_merge;
  logic             pop;
  logic             drain_load;
  logic             unused_bits;

  // Byte-address bit 0 is not part of a word address.
  assign unused_bits = cpu_addr[0] ^ rd_addr[0] ^ (^tail_entry);

  wrbuf_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (lat_entry),
    .merge       (merge),
    .merge_entry (merge_entry),
    .pop         (pop),
    .cmp_addr    (rd_addr[AW-1:1]),
    .head_entry  (head_entry),
    .tail_entry  (tail_entry),
    .count       (count),
    .match       (match)
  );

  // ---------------- front FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) front_q <= F_IDLE;
    else       front_q <= front_d;
  end

  always_comb begin
    front_d    = front_q;
    front_take = 1'b0;
    push       = 1'b0;
    merge      = 1'b0;
    case (front_q)
      F_IDLE: begin
        if (cpu_req && (count < CW'(DEPTH))) begin
          front_take = 1'b1;
          front_d    = F_CACHE;
        end
      end
      F_CACHE: begin
        if (cache_wr_ack) begin
          push    = !can_merge;
          merge   = can_merge;
          front_d = F_ACK;
        end
      end
      F_ACK: begin
        if (!cpu_req) front_d = F_IDLE;
      end
      default: front_d = F_IDLE;
    endcase
  end

  assign cache_req = (front_q == F_CACHE);
  assign cpu_ack   = (front_q == F_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_entry <= '0;
    end else if (front_take) begin
      lat_entry <= {cpu_addr[AW-1:1], cpu_data, cpu_uds_n, cpu_lds_n};
    end
  end

`ifdef WRBUF_MERGE_EN
  // With a single entry, that entry is either being drained or is loaded
  // into the drain registers this very cycle, so merging needs count >= 2.
  assign can_merge = (count >= CW'(2)) &&
                     (tail_entry[WRBUF_ADDR_OFF +: AW-1] == lat_entry[WRBUF_ADDR_OFF +: AW-1]);

  always_comb begin
    merge_entry = tail_entry;
    if (!lat_entry[WRBUF_UDS_OFF])
      merge_entry[WRBUF_DATA_OFF+8 +: 8] = lat_entry[WRBUF_DATA_OFF+8 +: 8];
    if (!lat_entry[WRBUF_LDS_OFF])
      merge_entry[WRBUF_DATA_OFF +: 8] = lat_entry[WRBUF_DATA_OFF +: 8];
    merge_entry[WRBUF_UDS_OFF] = tail_entry[WRBUF_UDS_OFF] & lat_entry[WRBUF_UDS_OFF];
    merge_entry[WRBUF_LDS_OFF] = tail_entry[WRBUF_LDS_OFF] & lat_entry[WRBUF_LDS_OFF];
  end
`else
  assign can_merge   = 1'b0;
  assign merge_entry = lat_entry;
`endif

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drain_q <= D_IDLE;
    else       drain_q <= drain_d;
  end

  // An sdram_wr_ack seen in D_IDLE falls through both branches unused.
  always_comb begin
    drain_d    = drain_q;
    drain_load = 1'b0;
    pop        = 1'b0;
    case (drain_q)
      D_IDLE: begin
        if (count != '0) begin
          drain_load = 1'b1;
          drain_d    = D_BUSY;
        end
      end
      D_BUSY: begin
        if (sdram_wr_ack) begin
          pop     = 1'b1;
          drain_d = D_IDLE;
        end
      end
    endcase
  end

  // Drain outputs are registered so they stay stable through D_BUSY; the
  // asynchronous reset drops sdram_req without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      sdram_data  <= '0;
      sdram_uds_n <= 1'b1;
      sdram_lds_n <= 1'b1;
    end else if (drain_load) begin
      sdram_req   <= 1'b1;
      sdram_addr  <= {head_entry[WRBUF_ADDR_OFF +: AW-1], 1'b0};
      sdram_data  <= head_entry[WRBUF_DATA_OFF +: WRBUF_DATA_W];
      sdram_uds_n <= head_entry[WRBUF_UDS_OFF];
      sdram_lds_n <= head_entry[WRBUF_LDS_OFF];
    end else if (pop) begin
      sdram_req   <= 1'b0;
    end
  end

  // The head stays in the FIFO (and in the compare) until popped; the write
  // still waiting on the cache is not in the FIFO yet, so check it here.
  assign rd_hold = (|match) ||
                   ((front_q == F_CACHE) &&
                    (lat_entry[WRBUF_ADDR_OFF +: AW-1] == rd_addr[AW-1:1]));

  assign empty = (count == '0) && (front_q != F_CACHE);

  assign dbg = '{front: front_q, drain: drain_q, count: 5'(count)};

endmodule

// File: tb/tb_cpu_write_buffer.sv
module tb_cpu_write_buffer;
  import minimig_cache_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int SBW   = AW + 16 + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_req      = 1'b0;
  logic [AW-1:0] cpu_addr     = '0;
  logic [15:0]   cpu_data     = '0;
  logic          cpu_uds_n    = 1'b1;
  logic          cpu_lds_n    = 1'b1;
  logic [AW-1:0] rd_addr      = '0;
  logic          cache_wr_ack = 1'b0;
  logic          sdram_wr_ack = 1'b0;
  logic          cache_auto   = 1'b1;

  logic          cpu_ack, rd_hold, cache_req, sdram_req;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_data;
  logic          sdram_uds_n, sdram_lds_n, empty;
  wrbuf_dbg_t    dbg;

  cpu_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cpu_uds_n    (cpu_uds_n),
    .cpu_lds_n    (cpu_lds_n),
    .cpu_ack      (cpu_ack),
    .rd_addr      (rd_addr),
    .rd_hold      (rd_hold),
    .cache_req    (cache_req),
    .cache_wr_ack (cache_wr_ack),
    .sdram_req    (sdram_req),
    .sdram_addr   (sdram_addr),
    .sdram_data   (sdram_data),
    .sdram_uds_n  (sdram_uds_n),
    .sdram_lds_n  (sdram_lds_n),
    .sdram_wr_ack (sdram_wr_ack),
    .empty        (empty),
    .dbg          (dbg)
  );

  // Cache model: acknowledges a notify one cycle after seeing it.
  always @(negedge clk) begin
    cache_wr_ack = cache_auto && cache_req && !cache_wr_ack;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [SBW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          uds_n;
    logic          lds_n;
    logic [AW-1:0] exp_addr;
  } wr_vec_t;

  typedef struct {
    logic [AW-1:0] rd_addr;
    logic          exp_hold;
  } hold_vec_t;

  wr_vec_t   wr_tab[4];
  hold_vec_t hold_tab[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [AW-1:0] a, input logic [15:0] d,
                           input logic u, input logic l, input logic [AW-1:0] ea);
    int n;
    @(negedge clk);
    cpu_addr  = a;
    cpu_data  = d;
    cpu_uds_n = u;
    cpu_lds_n = l;
    cpu_req   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 50);
    check("cpu_ack_seen", cpu_ack, 1);
    cpu_req = 1'b0;
    exp_q.push_back({ea, d, u, l});
    @(negedge clk);
  endtask

  task automatic drain_one(input string name);
    logic [SBW-1:0] exp;
    int n;
    n = 0;
    while (!sdram_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_req"}, sdram_req, 1);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue actual=empty expected=entry", name);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_word"}, {sdram_addr, sdram_data, sdram_uds_n, sdram_lds_n}, exp);
    end
    sdram_wr_ack = 1'b1;
    @(negedge clk);
    sdram_wr_ack = 1'b0;
    check({name, "_req_drop"}, sdram_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    wr_tab[0]   = '{32'h0000_2000, 16'h1111, 1'b0, 1'b0, 32'h0000_2000};
    wr_tab[1]   = '{32'h0000_2003, 16'h2222, 1'b1, 1'b0, 32'h0000_2002};
    wr_tab[2]   = '{32'hFFFF_FFFF, 16'h3333, 1'b0, 1'b1, 32'hFFFF_FFFE};
    wr_tab[3]   = '{32'h0000_0000, 16'h0000, 1'b0, 1'b0, 32'h0000_0000};
    hold_tab[0] = '{32'h0000_0101, 1'b1};
    hold_tab[1] = '{32'h0000_0100, 1'b1};
    hold_tab[2] = '{32'h0000_0102, 1'b0};
    hold_tab[3] = '{32'h8000_0100, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cache_req", cache_req, 0);
    check("rst_sdram_req", sdram_req, 0);
    check("rst_empty", empty, 1);
    check("rst_uds_n", sdram_uds_n, 1);
    check("rst_lds_n", sdram_lds_n, 1);
    check("rst_rd_hold", rd_hold, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single write, cycle by cycle
    cpu_addr = 32'h0000_1234; cpu_data = 16'hBEEF;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    check("t1_cache_req", cache_req, 1);
    check("t1_no_ack_yet", cpu_ack, 0);
    check("t1_not_empty", empty, 0);
    @(negedge clk);
    check("t1_cpu_ack", cpu_ack, 1);
    check("t1_cache_req_drop", cache_req, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("t1_ack_drop", cpu_ack, 0);
    check("t1_sdram_req", sdram_req, 1);
    check("t1_sdram_word", {sdram_addr, sdram_data, sdram_uds_n, sdram_lds_n},
          {32'h0000_1234, 16'hBEEF, 1'b0, 1'b0});
    sdram_wr_ack = 1'b1;
    @(negedge clk);
    sdram_wr_ack = 1'b0;
    check("t1_sdram_req_drop", sdram_req, 0);
    check("t1_empty", empty, 1);

    // Stray sdram_wr_ack while idle must not underflow the count
    sdram_wr_ack = 1'b1;
    @(negedge clk);
    sdram_wr_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_count", dbg.count, 0);
    check("idle_ack_empty", empty, 1);
    check("idle_ack_req", sdram_req, 0);

    // Table: single write/drain round trips (bit 0 ignored, enable mixes)
    for (int i = 0; i < 4; i++) begin
      cpu_write(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].uds_n, wr_tab[i].lds_n,
                wr_tab[i].exp_addr);
      drain_one($sformatf("tab%0d", i));
    end
    check("tab_empty", empty, 1);

    // 2: five writes with the drain stalled
    for (int i = 0; i < 4; i++) begin
      cpu_write(32'h0000_3000 + 32'(2 * i), 16'h5000 + 16'(i), 1'b0, 1'b0,
                32'h0000_3000 + 32'(2 * i));
    end
    check("t2_count_full", dbg.count, 4);
    @(negedge clk);
    cpu_addr = 32'h0000_3100; cpu_data = 16'h5555;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t2_full_no_cache_req", cache_req, 0);
    check("t2_full_no_ack", cpu_ack, 0);
    check("t2_full_front", dbg.front, F_IDLE);
    drain_one("t2_d0");
    n = 0;
    while (!cpu_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t2_fifth_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    exp_q.push_back({32'h0000_3100, 16'h5555, 1'b0, 1'b0});
    @(negedge clk);
    for (int i = 1; i < 5; i++) drain_one($sformatf("t2_d%0d", i));
    check("t2_empty", empty, 1);

    // 3: push and pop on the same clock
    cpu_write(wr_tab[0].addr, wr_tab[0].data, wr_tab[0].uds_n, wr_tab[0].lds_n, wr_tab[0].exp_addr);
    cpu_write(wr_tab[1].addr, wr_tab[1].data, wr_tab[1].uds_n, wr_tab[1].lds_n, wr_tab[1].exp_addr);
    check("t3_count_before", dbg.count, 2);
    cpu_addr = wr_tab[2].addr; cpu_data = wr_tab[2].data;
    cpu_uds_n = wr_tab[2].uds_n; cpu_lds_n = wr_tab[2].lds_n; cpu_req = 1'b1;
    @(negedge clk);
    check("t3_cache_req", cache_req, 1);
    check("t3_head_req", sdram_req, 1);
    check("t3_head_word", {sdram_addr, sdram_data, sdram_uds_n, sdram_lds_n}, exp_q.pop_front());
    sdram_wr_ack = 1'b1;
    @(negedge clk);
    sdram_wr_ack = 1'b0;
    check("t3_count_same", dbg.count, 2);
    check("t3_cpu_ack", cpu_ack, 1);
    check("t3_req_drop", sdram_req, 0);
    cpu_req = 1'b0;
    exp_q.push_back({wr_tab[2].exp_addr, wr_tab[2].data, wr_tab[2].uds_n, wr_tab[2].lds_n});
    @(negedge clk);
    drain_one("t3_d1");
    drain_one("t3_d2");
    check("t3_empty", empty, 1);

    // 4: read-after-write hazard
    cpu_write(32'h0000_0100, 16'h1234, 1'b0, 1'b0, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      rd_addr = hold_tab[i].rd_addr;
      #1;
      check($sformatf("t4_hold%0d", i), rd_hold, hold_tab[i].exp_hold);
    end
    cache_auto = 1'b0;
    @(negedge clk);
    cpu_addr = 32'h0000_0300; cpu_data = 16'h4321;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    check("t4_cache_wait", cache_req, 1);
    rd_addr = 32'h0000_0301;
    #1;
    check("t4_hold_at_cache", rd_hold, 1);
    cache_auto = 1'b1;
    n = 0;
    while (!cpu_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    exp_q.push_back({32'h0000_0300, 16'h4321, 1'b0, 1'b0});
    @(negedge clk);
    drain_one("t4_d0");
    drain_one("t4_d1");
    rd_addr = 32'h0000_0100;
    #1;
    check("t4_hold_cleared", rd_hold, 0);
    rd_addr = 32'h0000_0300;
    #1;
    check("t4_hold_cleared2", rd_hold, 0);

    // 5: byte writes to the same word with the drain stalled
    cpu_write(32'h0000_0400, 16'h7777, 1'b0, 1'b0, 32'h0000_0400);
    cpu_write(32'h0000_0200, 16'hAA00, 1'b0, 1'b1, 32'h0000_0200);
    cpu_write(32'h0000_0200, 16'h0055, 1'b1, 1'b0, 32'h0000_0200);
`ifdef WRBUF_MERGE_EN
    check("t5_count_merged", dbg.count, 2);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    exp_q.push_back({32'h0000_0200, 16'hAA55, 1'b0, 1'b0});
`else
    check("t5_count_separate", dbg.count, 3);
`endif
    n = 0;
    while (exp_q.size() > 0 && n < 8) begin
      drain_one($sformatf("t5_d%0d", n));
      n++;
    end
    check("t5_empty", empty, 1);

    // 6: reset while draining with three entries
    cpu_write(32'h0000_0500, 16'h0A0A, 1'b0, 1'b0, 32'h0000_0500);
    cpu_write(32'h0000_0502, 16'h0B0B, 1'b0, 1'b0, 32'h0000_0502);
    cpu_write(32'h0000_0504, 16'h0C0C, 1'b0, 1'b0, 32'h0000_0504);
    check("t6_count", dbg.count, 3);
    check("t6_busy", dbg.drain, D_BUSY);
    check("t6_req_before", sdram_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_req_async", sdram_req, 0);
    check("t6_empty", empty, 1);
    check("t6_cpu_ack", cpu_ack, 0);
    check("t6_count_clear", dbg.count, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Recovery after reset
    cpu_write(32'h0000_0600, 16'hC0DE, 1'b0, 1'b0, 32'h0000_0600);
    drain_one("post_rst");
    check("post_rst_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
